rv_divide: RTL and testbench
============================

// Module: rv_divide
// PURPOSE
//  Iterative 32-bit integer divider for the RV32M execute stage; inverse of the
//  single-cycle DSP multiplier. Implements DIV/DIVU/REM/REMU by radix-2 restoring
//  division. Sits beside the multiplier; the pipeline holds x-stage while busy_o.
// PARAMETERS
//  (none) - width fixed at 32; iteration count fixed at 32.
// PORTS
//  clk_i       in   1   clock, all flops on rising edge
//  rst_n_i     in   1   reset, asynchronous, active-low
//  start_i     in   1   request; sampled only in IDLE
//  kill_i      in   1   abort current operation (pipeline flush)
//  d_rs1_i     in   32  dividend
//  d_rs2_i     in   32  divisor
//  d_fun_i     in   3   funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  busy_o      out  1   high from the edge accepting start_i until done_o
//  done_o      out  1   one-cycle pulse, w_rd_o valid
//  w_rd_o      out  32  result, held until the next accepted start_i
// BEHAVIOUR
//  - Reset: state=IDLE, busy_o=0, done_o=0, w_rd_o=0, all internals 0.
//  - States: IDLE -> PREP -> ITER(x32) -> FIX -> IDLE.
//  - IDLE: start_i=1 & kill_i=0 latches rs1/rs2/fun; -> PREP; busy_o=1.
//    Operand inputs are don't-care after the accepting edge.
//  - PREP: signed ops (fun[0]=0) take |rs1|,|rs2|, record sign_q=rs1[31]^rs2[31]
//    and sign_r=rs1[31]; flag div0 (rs2==0), ovf (DIV/REM, rs1=0x80000000,
//    rs2=0xFFFFFFFF). Clear remainder, count=0; -> ITER.
//  - ITER: per cycle shift {rem,quo} left 1; if rem>=divisor subtract and set
//    quo[0]. count 0..31; after count==31 -> FIX. Remainder register 33 bits.
//  - FIX: negate quo if sign_q, rem if sign_r (signed ops only); select quo
//    (fun[1]=0) or rem (fun[1]=1) into w_rd_o; done_o=1; busy_o=0; -> IDLE.
//  - Latency: start sampled at edge N; done_o high after edge N+34.
//  - Special results (RISC-V spec): div0: quo=0xFFFFFFFF, rem=rs1 (all 4 ops);
//    ovf: quo=0x80000000, rem=0. Forced in FIX, override iteration result.
//  - start_i while busy: ignored, no queueing.
//  - kill_i in any non-IDLE state: -> IDLE next edge, busy_o=0, no done_o,
//    w_rd_o keeps prior value. kill_i with start_i in IDLE: start ignored.
//  - start_i in the cycle done_o is high: accepted (state already IDLE).
//  - Reset mid-operation: immediate return to reset values.
// CONFIGURATION
//  RV_DIV_EARLY_OUT_EN defined: PREP detecting div0 or ovf goes directly to FIX;
//   done_o after edge N+2, busy_o cleared there. Normal ops unchanged.
//  Undefined: special cases run full 34-cycle latency; results identical.
// STRUCTURE
//  - rv_defs.v: funct3 constants (`FUNC_DIV, `FUNC_DIVU, `FUNC_REM, `FUNC_REMU)
//    and the 2-bit state encodings shared with the execute-stage stall logic.
//  - Sub-module rv_div_step: combinational one-bit restoring step
//    (rem_in, quo_in, divisor -> rem_out, quo_out); instantiated once.
// TESTING
//  1 DIVU 100/7 -> done after 34 cycles, w_rd_o=14; REMU same -> 2.
//  2 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 1.
//  3 DIVU/REM x/0 with x=0x1234 -> quo 0xFFFFFFFF, rem 0x1234; with
//    RV_DIV_EARLY_OUT_EN done after 2 cycles, else 34.
//  4 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU same operands -> 0.
//  5 kill_i at ITER count 10 -> busy_o low next cycle, no done_o, w_rd_o unchanged;
//    new start then completes correctly.
//  6 start_i pulsed at cycle 5 of an op -> ignored, single done_o; rst_n_i low
//    mid-ITER -> all outputs 0 asynchronously.
//  Scoreboard: random 10k ops vs. reference model, signed/unsigned corner sets.

Source files
------------

// File: rtl/rv_divide_pkg.sv
// -----------------------------------------------------------------------------
// rv_divide_pkg
// Shared definitions for the RV32M iterative divider: the datapath width, the
// funct3 encodings of DIV/DIVU/REM/REMU, and the 2-bit FSM state encoding that
// the execute-stage stall logic also decodes.
// -----------------------------------------------------------------------------
package rv_divide_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] FUNC_DIV  = 3'b100;
  localparam logic [2:0] FUNC_DIVU = 3'b101;
  localparam logic [2:0] FUNC_REM  = 3'b110;
  localparam logic [2:0] FUNC_REMU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } div_state_e;

endpackage

// File: rtl/rv_div_step.sv
// -----------------------------------------------------------------------------
// rv_div_step
// One combinational radix-2 restoring division step. The {rem,quo} pair is
// shifted left by one; if the shifted remainder is at least the divisor, the
// divisor is subtracted and the new quotient bit is 1.
// Ports:
//   rem_i  [DATA_W:0]    partial remainder in
//   quo_i  [DATA_W-1:0]  dividend/quotient shift register in
//   dvs_i  [DATA_W-1:0]  divisor (magnitude)
//   rem_o  [DATA_W:0]    partial remainder out
//   quo_o  [DATA_W-1:0]  quotient shift register out
// -----------------------------------------------------------------------------
module rv_div_step
  import rv_divide_pkg::*;
(
  input  logic [DATA_W:0]   rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W:0]   rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W+1:0] shl;
  logic [DATA_W+1:0] diff;

  // One extra bit above the remainder so the subtraction borrow is the MSB.
  assign shl  = {rem_i, quo_i[DATA_W-1]};
  assign diff = shl - {2'b00, dvs_i};

  assign quo_o = {quo_i[DATA_W-2:0], ~diff[DATA_W+1]};
  assign rem_o = diff[DATA_W+1] ? shl[DATA_W:0] : diff[DATA_W:0];

endmodule

// File: rtl/rv_divide.sv
// -----------------------------------------------------------------------------
// rv_divide
// Iterative 32-bit integer divider for the RV32M execute stage (DIV, DIVU,
// REM, REMU) using radix-2 restoring division. Sequence per operation:
// IDLE -> PREP -> ITER (32 cycles) -> FIX -> IDLE, so done_o rises 34 edges
// after the edge that accepted start_i. The pipeline holds x-stage while
// busy_o is high.
//
// Ports:
//   clk_i     in   1   clock, rising edge
//   rst_n_i   in   1   asynchronous active-low reset
//   start_i   in   1   request, sampled only in IDLE
//   kill_i    in   1   abort (pipeline flush); also blocks start_i in IDLE
//   d_rs1_i   in   32  dividend
//   d_rs2_i   in   32  divisor
//   d_fun_i   in   3   funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   busy_o    out  1   high from the accepting edge until done_o
//   done_o    out  1   one-cycle pulse, w_rd_o valid
//   w_rd_o    out  32  result, held until replaced by the next completion
//
// Configuration macro:
//   RV_DIV_EARLY_OUT_EN  when defined, divide-by-zero and signed overflow skip
//                        the iterations (PREP -> FIX), done_o two edges after
//                        acceptance. Results are identical either way.
// -----------------------------------------------------------------------------
module rv_divide
  import rv_divide_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              kill_i,
  input  logic [DATA_W-1:0] d_rs1_i,
  input  logic [DATA_W-1:0] d_rs2_i,
  input  logic [2:0]        d_fun_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] w_rd_o
);

  localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ALL_ONE = {DATA_W{1'b1}};

  div_state_e        state_q;
  logic [DATA_W-1:0] rs1_q, rs2_q;
  logic [2:0]        fun_q;
  logic [DATA_W:0]   rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;
  logic [4:0]        cnt_q;
  logic              sgnq_q, sgnr_q;
  logic              div0_q, ovf_q;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] rd_q;

  // Two's-complement magnitude of a signed operand; INT_MIN maps onto itself,
  // which is still the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic [DATA_W-1:0] neg_cond(input logic [DATA_W-1:0] v,
                                                 input logic              en);
    return en ? (~v + DATA_W'(1)) : v;
  endfunction

  logic is_signed, is_rem;
  assign is_signed = (fun_q == FUNC_DIV) || (fun_q == FUNC_REM);
  assign is_rem    = (fun_q == FUNC_REM) || (fun_q == FUNC_REMU);

  logic div0_w, ovf_w;
  assign div0_w = (rs2_q == '0);
  assign ovf_w  = is_signed && (rs1_q == INT_MIN) && (rs2_q == ALL_ONE);

  logic [DATA_W:0]   rem_step;
  logic [DATA_W-1:0] quo_step;

  rv_div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  // Final sign correction plus the architecturally defined special results.
  logic [DATA_W-1:0] quo_fix, rem_fix, res_fix;
  always_comb begin
    quo_fix = neg_cond(quo_q, sgnq_q);
    rem_fix = neg_cond(rem_q[DATA_W-1:0], sgnr_q);
    if (div0_q) begin
      quo_fix = ALL_ONE;
      rem_fix = rs1_q;
    end else if (ovf_q) begin
      quo_fix = INT_MIN;
      rem_fix = '0;
    end
    res_fix = is_rem ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      fun_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (kill_i) begin
        // Flush wins over everything, including a pending start in IDLE.
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          // IDLE: capture the request
          ST_IDLE: begin
            if (start_i) begin
              rs1_q   <= d_rs1_i;
              rs2_q   <= d_rs2_i;
              fun_q   <= d_fun_i;
              busy_q  <= 1'b1;
              state_q <= ST_PREP;
            end
          end
          // PREP: magnitudes, result signs, special-case flags
          ST_PREP: begin
            quo_q  <= is_signed ? abs_val(rs1_q) : rs1_q;
            dvs_q  <= is_signed ? abs_val(rs2_q) : rs2_q;
            sgnq_q <= is_signed && (rs1_q[DATA_W-1] ^ rs2_q[DATA_W-1]);
            sgnr_q <= is_signed && rs1_q[DATA_W-1];
            div0_q <= div0_w;
            ovf_q  <= ovf_w;
            rem_q  <= '0;
            cnt_q  <= '0;
`ifdef RV_DIV_EARLY_OUT_EN
            state_q <= (div0_w || ovf_w) ? ST_FIX : ST_ITER;
`else
            state_q <= ST_ITER;
`endif
          end
          // ITER: one quotient bit per cycle
          ST_ITER: begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= ST_FIX;
          end
          // FIX: sign-correct, select, publish
          ST_FIX: begin
            rd_q    <= res_fix;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign w_rd_o = rd_q;

endmodule

// File: tb/tb_rv_divide.sv
module tb_rv_divide;

`ifdef RV_DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 2;
`else
  localparam int SPEC_LAT = 34;
`endif
  localparam int NORM_LAT = 34;
  localparam int MAX_WAIT = 100;

  logic        clk, rst_n, start, kill;
  logic [31:0] rs1, rs2;
  logic [2:0]  fun;
  logic        busy, done;
  logic [31:0] w_rd;

  int n_tot  = 0;
  int n_pass = 0;

  rv_divide dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .kill_i  (kill),
    .d_rs1_i (rs1),
    .d_rs2_i (rs2),
    .d_fun_i (fun),
    .busy_o  (busy),
    .done_o  (done),
    .w_rd_o  (w_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Independent reference for the random section.
  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f[1] ? 32'd0 : 32'h8000_0000;
    if (!f[0]) return f[1] ? 32'(sa % sb) : 32'(sa / sb);
    return f[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issue one op, scramble operands after acceptance, wait for done_o.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat,
                       output logic busy_acc, output logic busy_done);
    @(negedge clk);
    start = 1'b1; fun = f; rs1 = a; rs2 = b;
    @(posedge clk);
    #1;
    busy_acc = busy;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; fun = 3'($urandom);
    lat = 0;
    busy_done = 1'b1;
    while (lat < MAX_WAIT) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
    end
    busy_done = busy;
    res = w_rd;
  endtask

  initial begin
    logic [31:0] res, prev;
    int          lat, dcount;
    logic        bacc, bdone;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    vecs.push_back('{3'b101, 32'd100,        32'd7,          32'd14,         1'b0, "divu_100_7"});
    vecs.push_back('{3'b111, 32'd100,        32'd7,          32'd2,          1'b0, "remu_100_7"});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, "div_m7_2"});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, "rem_m7_2"});
    vecs.push_back('{3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, "rem_7_m2"});
    vecs.push_back('{3'b100, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  1'b0, "div_100_m7"});
    vecs.push_back('{3'b110, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0, "rem_m100_7"});
    vecs.push_back('{3'b101, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1'b1, "divu_x_0"});
    vecs.push_back('{3'b111, 32'h0000_1234,  32'd0,          32'h0000_1234,  1'b1, "remu_x_0"});
    vecs.push_back('{3'b100, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1'b1, "div_x_0"});
    vecs.push_back('{3'b110, 32'h0000_1234,  32'd0,          32'h0000_1234,  1'b1, "rem_x_0"});
    vecs.push_back('{3'b110, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FF9C,  1'b1, "rem_m100_0"});
    vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, "div_ovf"});
    vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1, "rem_ovf"});
    vecs.push_back('{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, "divu_big"});
    vecs.push_back('{3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, "remu_big"});
    vecs.push_back('{3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, "divu_max_1"});
    vecs.push_back('{3'b111, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0, "remu_max"});
    vecs.push_back('{3'b100, 32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0, "div_min_2"});

    start = 1'b0; kill = 1'b0; rs1 = '0; rs2 = '0; fun = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rd",   w_rd,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven directed vectors (each start lands in the prior done cycle).
    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, bacc, bdone);
      check({vecs[i].name, "_res"}, res, vecs[i].exp);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].special ? SPEC_LAT : NORM_LAT));
      check({vecs[i].name, "_busy_acc"}, 32'(bacc), 32'd1);
      check({vecs[i].name, "_busy_done"}, 32'(bdone), 32'd0);
    end

    // done_o is a single-cycle pulse.
    @(posedge clk);
    #1;
    check("done_pulse_width", 32'(done), 32'd0);

    // Random ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      rf = 3'b100 | 3'($urandom_range(0, 3));
      ra = $urandom;
      case (i % 4)
        0: rb = 32'($urandom_range(1, 20));
        1: rb = $urandom;
        2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      do_op(rf, ra, rb, res, lat, bacc, bdone);
      check($sformatf("rand%0d_f%0b_%h_%h", i, rf, ra, rb), res, ref_div(rf, ra, rb));
      check($sformatf("rand%0d_lat", i), 32'(lat),
            32'(is_special(rf, ra, rb) ? SPEC_LAT : NORM_LAT));
    end

    // kill with start in IDLE: start ignored.
    prev = w_rd;
    @(negedge clk);
    start = 1'b1; kill = 1'b1; fun = 3'b101; rs1 = 32'd50; rs2 = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    check("kill_start_idle_busy", 32'(busy), 32'd0);

    // kill at ITER count 10.
    @(negedge clk);
    start = 1'b1; fun = 3'b101; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_busy_low", 32'(busy), 32'd0);
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("kill_no_done", 32'(dcount), 32'd0);
    check("kill_rd_kept", w_rd, prev);
    do_op(3'b101, 32'd1000, 32'd3, res, lat, bacc, bdone);
    check("after_kill_res", res, 32'd333);
    check("after_kill_lat", 32'(lat), 32'(NORM_LAT));

    // start pulsed while busy: ignored, single done.
    @(negedge clk);
    start = 1'b1; fun = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; fun = 3'b111; rs1 = 32'd200; rs2 = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    dcount = 0;
    res = 32'hDEAD_BEEF;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dcount++;
        if (dcount == 1) res = w_rd;
      end
    end
    check("busy_start_single_done", 32'(dcount), 32'd1);
    check("busy_start_res", res, 32'd14);

    // Asynchronous reset mid-ITER.
    @(negedge clk);
    start = 1'b1; fun = 3'b100; rs1 = 32'd999; rs2 = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_rd",   w_rd,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'b100, 32'd999, 32'd9, res, lat, bacc, bdone);
    check("after_rst_res", res, 32'd111);
    check("after_rst_lat", 32'(lat), 32'(NORM_LAT));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
